// File: rtl/cnn_conv_acc.sv
// Kernel-window accumulator: bias pre-load, saturating signed accumulation,
// then arithmetic rescale, ReLU and clamp to a signed activation.
module cnn_conv_acc #(
    parameter int unsigned PROD_W  = 25,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned N_TERMS = 25,
    parameter int unsigned SHIFT   = 8,
    parameter int unsigned OUT_W   = 14
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_din,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [ACC_W-1:0]  bias_din,
    output logic [OUT_W-1:0]         res_dout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     sat_flag
);

    localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {StAcc, StFin, StOut} state_e;

    state_e                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;

    logic signed [ACC_W-1:0]  add_base;
    logic signed [ACC_W:0]    sum;
    logic                     add_sat;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]         res_next;

    assign prod_ready = (state == StAcc);

    always_comb begin
        // The first product of a window adds onto the bias instead of the old sum.
        add_base = (cnt == '0) ? bias_din : acc;
        sum      = {add_base[ACC_W-1], add_base}
                 + {{(ACC_W+1-PROD_W){prod_din[PROD_W-1]}}, prod_din};
        add_sat  = (sum[ACC_W] != sum[ACC_W-1]);
        if (add_sat) begin
            acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum[ACC_W-1:0];
        end

        shifted = acc >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            res_next = '0;
        end else if (shifted > OUT_MAX) begin
            res_next = OUT_MAX[OUT_W-1:0];
        end else begin
            res_next = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= StAcc;
            acc       <= '0;
            cnt       <= '0;
            res_dout  <= '0;
            res_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            unique case (state)
                StAcc: begin
                    if (prod_valid) begin
                        acc <= acc_next;
                        if (add_sat) begin
                            sat_flag <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= StFin;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StFin: begin
                    res_dout  <= res_next;
                    res_valid <= 1'b1;
                    state     <= StOut;
                end
                StOut: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= StAcc;
                    end
                end
                default: state <= StAcc;
            endcase
        end
    end

endmodule
